// File: rtl/tc_multi_pkg.sv
// rtl/tc_multi_pkg.sv - shared types and constants for the multi-channel timer/counter
// Contents: channel FSM state enum, register offsets, CTRL bit positions,
// MODE encodings and small width helpers used by tc_channel and tc_multi.
package tc_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } tc_state_t;

  // Register offsets, selected by Addr[3:2]
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // CTRL bit positions; PEND sits above the PS field, see ctrl_pend_bit
  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_IM   = 3;
  localparam int CTRL_PS   = 4;

  // MODE encodings; 2'b1x behaves as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  function automatic int ctrl_pend_bit(input int psw);
    return 8 + psw;
  endfunction

  // Channel index width: max(1, clog2(nch))
  function automatic int ch_width(input int nch);
    return (nch <= 2) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/tc_channel.sv
// rtl/tc_channel.sv - one timer channel: CTRL/PRESET/COUNT, prescaler and FSM
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   we           - write strobe already decoded for this channel
//   reg_sel      - register offset (Addr[3:2])
//   wdata        - write data
//   rdata        - combinational read data for reg_sel
//   irq          - pending & IM
module tc_channel
  import tc_multi_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PSW   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  // Prescale counter must hold 2^PS-1 for the largest PS = 2^PSW-1
  localparam int PCW      = (1 << PSW) - 1;
  localparam int PEND_BIT = ctrl_pend_bit(PSW);

  tc_state_t        state;
  logic             en;
  logic [1:0]       mode;
  logic             im;
  logic [PSW-1:0]   ps;
  logic             pend;
  logic [WIDTH-1:0] preset;
  logic [WIDTH-1:0] count;
  logic [PCW-1:0]   pscnt;

  logic [PCW-1:0]   ps_mask;
  logic             tick;
  logic             unused_wdata;

  // Masked compare keeps ticking sane when PS shrinks while pscnt is above the new limit
  assign ps_mask = ~({PCW{1'b1}} << ps);
  assign tick    = (state == ST_CNT) && ((pscnt & ps_mask) == ps_mask);
  assign irq     = pend & im;
  assign unused_wdata = ^wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      en     <= 1'b0;
      mode   <= MODE_ONESHOT;
      im     <= 1'b0;
      ps     <= '0;
      pend   <= 1'b0;
      preset <= '0;
      count  <= '0;
      pscnt  <= '0;
    end else begin
      if (we) begin
        case (reg_sel)
          REG_CTRL: begin
            en   <= wdata[CTRL_EN];
            mode <= wdata[CTRL_MODE +: 2];
            im   <= wdata[CTRL_IM];
            ps   <= wdata[CTRL_PS +: PSW];
            if (wdata[PEND_BIT]) pend <= 1'b0;
          end
          REG_PRESET: preset <= wdata[WIDTH-1:0];
          default: ;
        endcase
      end

      // FSM assignments come after the register write so that a hardware
      // PEND set and the one-shot EN clear win over same-cycle writes.
      if (!en) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: state <= ST_LOAD;
          ST_LOAD: begin
            count <= preset;
            pscnt <= '0;
            state <= ST_CNT;
          end
          ST_CNT: begin
            if (tick) begin
              pscnt <= '0;
              // COUNT <= 1 also covers PRESET=0, which then expires like PRESET=1
              if (count > WIDTH'(1)) begin
                count <= count - WIDTH'(1);
              end else begin
                count <= '0;
                pend  <= 1'b1;
                state <= ST_INT;
              end
            end else begin
              pscnt <= pscnt + PCW'(1);
            end
          end
          ST_INT: begin
            if (mode == MODE_RELOAD) begin
              state <= ST_LOAD;
            end else begin
              en    <= 1'b0;
              state <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL: begin
        rdata[CTRL_EN]          = en;
        rdata[CTRL_MODE +: 2]   = mode;
        rdata[CTRL_IM]          = im;
        rdata[CTRL_PS +: PSW]   = ps;
        rdata[PEND_BIT]         = pend;
      end
      REG_PRESET: rdata[WIDTH-1:0] = preset;
      REG_COUNT:  rdata[WIDTH-1:0] = count;
      REG_RSVD:   rdata = '0;
      default:    rdata = '0;
    endcase
  end

endmodule

// File: rtl/tc_multi.sv
// rtl/tc_multi.sv - NCH-channel timer/counter on one CPU bridge slot
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   Addr         - word address PrAddr[31:2]; [3:2] register, [4+] channel
//   WE           - write strobe for this slot
//   Din          - write data
//   Dout         - combinational read data
//   irq          - per-channel pending & IM
//   irq_any      - OR of irq
module tc_multi
  import tc_multi_pkg::*;
#(
  parameter int NCH   = 2,
  parameter int WIDTH = 32,
  parameter int PSW   = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [31:2]    Addr,
  input  logic           WE,
  input  logic [31:0]    Din,
  output logic [31:0]    Dout,
  output logic [NCH-1:0] irq,
  output logic           irq_any
);

  localparam int CHW  = ch_width(NCH);
  // One extra index bit so that index NCH decodes as out of range
  // instead of aliasing onto channel 0 when NCH is a power of two.
  localparam int IDXW = CHW + 1;

  logic [IDXW-1:0] ch_idx;
  logic [1:0]      reg_sel;
  logic [31:0]     ch_rdata [NCH];
  logic [NCH-1:0]  ch_we;
  logic            unused_addr;

  assign ch_idx      = Addr[4 +: IDXW];
  assign reg_sel     = Addr[3:2];
  assign unused_addr = ^Addr[31:4+IDXW];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign ch_we[g] = WE && (ch_idx == IDXW'(g));

    tc_channel #(
      .WIDTH (WIDTH),
      .PSW   (PSW)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .we      (ch_we[g]),
      .reg_sel (reg_sel),
      .wdata   (Din),
      .rdata   (ch_rdata[g]),
      .irq     (irq[g])
    );
  end

  always_comb begin
    Dout = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_idx == IDXW'(i)) Dout = ch_rdata[i];
    end
  end

  assign irq_any = |irq;

endmodule
